// File: rtl/hi_flite_deframe.sv
// hi_flite_deframe: hunts preamble+SYNC in the demodulated bit stream and deframes length/payload/CRC-16 into bytes
// Ports:
//   ck_1356meg   in   carrier clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   enable       in   0 = silent return to HUNT, strobes ignored
//   bit_in       in   demodulated bit, qualified by bit_stb
//   bit_stb      in   one-cycle strobe per decoded bit
//   carrier_lost in   demodulator lost sync; aborts any frame in progress
//   byte_out     out  length/payload byte, valid with byte_stb
//   byte_stb     out  one-cycle pulse per delivered byte (never CRC bytes)
//   sof          out  one-cycle pulse on SYNC match
//   eof          out  one-cycle pulse after last CRC bit
//   crc_ok       out  CRC compare result, valid from eof until next sof
//   len_out      out  received length byte, held until next sof
//   busy         out  high whenever not hunting
//   abort        out  one-cycle pulse when a frame is dropped
module hi_flite_deframe #(
  parameter logic [15:0] SYNC_WORD    = 16'hB24D,
  parameter int          MIN_PREAMBLE = 16,
  parameter logic [15:0] CRC_POLY     = 16'h1021
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_stb,
  input  logic       carrier_lost,
  output logic [7:0] byte_out,
  output logic       byte_stb,
  output logic       sof,
  output logic       eof,
  output logic       crc_ok,
  output logic [7:0] len_out,
  output logic       busy,
  output logic       abort
);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] LEN  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] CRC  = 2'd3;
  logic [1:0]  state;
  logic [31:0] win, win_nx;
  logic [15:0] crc, crc_nx, rx_crc, rx_nx;
  logic [7:0]  sh, sh_nx, remaining;
  logic [3:0]  bitcnt;
  logic        match, byte_done;
  always_comb begin
    win_nx    = {win[30:0], bit_in};
    match     = (win_nx[15:0] == SYNC_WORD) && (win_nx[16 +: MIN_PREAMBLE] == '0);
    crc_nx    = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    sh_nx     = {sh[6:0], bit_in};
    rx_nx     = {rx_crc[14:0], bit_in};
    byte_done = bitcnt[2:0] == 3'd7;
  end
  assign busy = state != HUNT;
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      win       <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      sh        <= '0;
      remaining <= '0;
      bitcnt    <= '0;
      byte_out  <= '0;
      byte_stb  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      crc_ok    <= 1'b0;
      len_out   <= '0;
      abort     <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      abort    <= 1'b0;
      if (!enable) begin
        state  <= HUNT;
        win    <= '0;
        bitcnt <= '0;
      end else if (carrier_lost) begin
        // carrier loss outranks a coincident bit strobe; the bit is dropped
        abort  <= state != HUNT;
        state  <= HUNT;
        win    <= '0;
        bitcnt <= '0;
      end else if (bit_stb) begin
        case (state)
          HUNT: begin
            win <= win_nx;
            if (match) begin
              sof     <= 1'b1;
              crc     <= '0;
              bitcnt  <= '0;
              crc_ok  <= 1'b0;
              len_out <= '0;
              state   <= LEN;
            end
          end
          LEN: begin
            crc    <= crc_nx;
            sh     <= sh_nx;
            bitcnt <= byte_done ? 4'd0 : bitcnt + 4'd1;
            if (byte_done) begin
              if (sh_nx == 8'd0) begin
                abort <= 1'b1;
                state <= HUNT;
                win   <= '0;
              end else begin
                byte_stb  <= 1'b1;
                byte_out  <= sh_nx;
                len_out   <= sh_nx;
                remaining <= sh_nx - 8'd1;
                state     <= (sh_nx == 8'd1) ? CRC : DATA;
              end
            end
          end
          DATA: begin
            crc    <= crc_nx;
            sh     <= sh_nx;
            bitcnt <= byte_done ? 4'd0 : bitcnt + 4'd1;
            if (byte_done) begin
              byte_stb  <= 1'b1;
              byte_out  <= sh_nx;
              remaining <= remaining - 8'd1;
              state     <= (remaining == 8'd1) ? CRC : DATA;
            end
          end
          default: begin
            // running CRC is frozen here; received CRC shifts in separately
            rx_crc <= rx_nx;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd15) begin
              eof    <= 1'b1;
              crc_ok <= rx_nx == crc;
              state  <= HUNT;
              win    <= '0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hi_flite_deframe.sv
// tb_hi_flite_deframe: table-driven and scoreboard bench for hi_flite_deframe
module tb_hi_flite_deframe;
  logic       ck_1356meg = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic       bit_in = 1'b0, bit_stb = 1'b0, carrier_lost = 1'b0;
  logic [7:0] byte_out, len_out;
  logic       byte_stb, sof, eof, crc_ok, busy, abort;
  hi_flite_deframe dut (
    .ck_1356meg(ck_1356meg), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
    .bit_stb(bit_stb), .carrier_lost(carrier_lost), .byte_out(byte_out),
    .byte_stb(byte_stb), .sof(sof), .eof(eof), .crc_ok(crc_ok),
    .len_out(len_out), .busy(busy), .abort(abort)
  );
  always #5 ck_1356meg = ~ck_1356meg;
  typedef struct packed {logic ok; logic [7:0] len;} eof_t;
  typedef struct {logic [7:0] len; logic [7:0] first; logic bad; logic fast; logic exp_ok; int exp_bytes;} vec_t;
  int checks = 0, errors = 0;
  int n_sof = 0, n_eof = 0, n_abort = 0, n_byte = 0;
  logic [7:0] exp_q[$];
  eof_t eof_q[$];
  logic fast = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected pulse, expected none", name);
  endtask
  eof_t e;
  always @(negedge ck_1356meg) begin
    if (sof) n_sof++;
    if (abort) n_abort++;
    if (byte_stb) begin
      n_byte++;
      if (exp_q.size() == 0) unexpected("byte_stb");
      else chk("byte_out", int'(byte_out), int'(exp_q.pop_front()));
    end
    if (eof) begin
      n_eof++;
      if (eof_q.size() == 0) unexpected("eof");
      else begin
        e = eof_q.pop_front();
        chk("crc_ok", int'(crc_ok), int'(e.ok));
        chk("len_out_at_eof", int'(len_out), int'(e.len));
      end
    end
  end
  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  task automatic send_bit(input logic b);
    bit_in = b;
    bit_stb = 1'b1;
    @(negedge ck_1356meg);
    bit_stb = 1'b0;
    if (!fast) @(negedge ck_1356meg);
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge ck_1356meg);
  endtask
  task automatic send_hdr();
    repeat (48) send_bit(1'b0);
    send_byte(8'hB2);
    send_byte(8'h4D);
  endtask
  task automatic send_body(input logic [7:0] len, input logic [7:0] first, input logic bad);
    logic [15:0] c;
    logic [7:0] b;
    c = crc8(16'h0000, len);
    exp_q.push_back(len);
    eof_q.push_back({~bad, len});
    send_byte(len);
    for (int i = 1; i < int'(len); i++) begin
      b = first + 8'(i - 1);
      c = crc8(c, b);
      exp_q.push_back(b);
      send_byte(b);
    end
    if (bad) c = c ^ 16'h0001;
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int s0, e0, a0, b0;
    s0 = n_sof; e0 = n_eof; a0 = n_abort; b0 = n_byte;
    fast = v.fast;
    send_hdr();
    send_body(v.len, v.first, v.bad);
    idle(3);
    chk({tag, "_sof"}, n_sof - s0, 1);
    chk({tag, "_eof"}, n_eof - e0, 1);
    chk({tag, "_bytes"}, n_byte - b0, v.exp_bytes);
    chk({tag, "_abort"}, n_abort - a0, 0);
    chk({tag, "_crc_ok_held"}, int'(crc_ok), int'(v.exp_ok));
    chk({tag, "_len_out"}, int'(len_out), int'(v.len));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_queue_drained"}, exp_q.size() + eof_q.size(), 0);
  endtask
  task automatic chk_zero(input string name);
    chk(name, int'({byte_out, byte_stb, sof, eof, crc_ok, len_out, busy, abort}), 0);
  endtask
  vec_t vecs[6];
  vec_t v;
  int s0, e0, a0, b0;
  initial begin
    vecs[0] = '{len: 8'h01, first: 8'h00, bad: 1'b0, fast: 1'b0, exp_ok: 1'b1, exp_bytes: 1};
    vecs[1] = '{len: 8'h01, first: 8'h00, bad: 1'b1, fast: 1'b0, exp_ok: 1'b0, exp_bytes: 1};
    vecs[2] = '{len: 8'h03, first: 8'hA5, bad: 1'b0, fast: 1'b1, exp_ok: 1'b1, exp_bytes: 3};
    vecs[3] = '{len: 8'h03, first: 8'h5A, bad: 1'b1, fast: 1'b1, exp_ok: 1'b0, exp_bytes: 3};
    vecs[4] = '{len: 8'h0A, first: 8'h30, bad: 1'b0, fast: 1'b0, exp_ok: 1'b1, exp_bytes: 10};
    vecs[5] = '{len: 8'hFF, first: 8'h80, bad: 1'b0, fast: 1'b1, exp_ok: 1'b1, exp_bytes: 255};
    idle(2);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    fast = 1'b0;
    s0 = n_sof; e0 = n_eof;
    repeat (16) send_bit(1'b1);
    repeat (15) send_bit(1'b0);
    send_byte(8'hB2);
    send_byte(8'h4D);
    idle(2);
    chk("short_preamble_sof", n_sof - s0, 0);
    chk("short_preamble_busy", int'(busy), 0);
    repeat (16) send_bit(1'b0);
    send_byte(8'hB2);
    send_byte(8'h4D);
    idle(2);
    chk("min_preamble_sof", n_sof - s0, 1);
    chk("min_preamble_busy", int'(busy), 1);
    send_body(8'h01, 8'h00, 1'b0);
    idle(3);
    chk("min_preamble_eof", n_eof - e0, 1);
    a0 = n_abort; b0 = n_byte; e0 = n_eof;
    send_hdr();
    send_byte(8'h00);
    idle(2);
    chk("len0_abort", n_abort - a0, 1);
    chk("len0_bytes", n_byte - b0, 0);
    chk("len0_busy", int'(busy), 0);
    chk("len0_eof", n_eof - e0, 0);
    a0 = n_abort; b0 = n_byte; e0 = n_eof;
    send_hdr();
    exp_q.push_back(8'h06); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send_byte(8'h06);
    send_byte(8'h01);
    send_byte(8'h02);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    bit_in = 1'b1;
    bit_stb = 1'b1;
    carrier_lost = 1'b1;
    idle(1);
    bit_stb = 1'b0;
    carrier_lost = 1'b0;
    idle(2);
    chk("carrier_lost_abort", n_abort - a0, 1);
    chk("carrier_lost_bytes", n_byte - b0, 3);
    chk("carrier_lost_eof", n_eof - e0, 0);
    chk("carrier_lost_busy", int'(busy), 0);
    v = '{len: 8'h06, first: 8'h01, bad: 1'b0, fast: 1'b0, exp_ok: 1'b1, exp_bytes: 6};
    run_vec(v, "after_carrier_lost");
    fast = 1'b1;
    a0 = n_abort; b0 = n_byte; e0 = n_eof;
    send_hdr();
    exp_q.push_back(8'h04); exp_q.push_back(8'hAA);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    enable = 1'b0;
    send_bit(1'b1);
    enable = 1'b1;
    idle(2);
    chk("enable_drop_abort", n_abort - a0, 0);
    chk("enable_drop_eof", n_eof - e0, 0);
    chk("enable_drop_bytes", n_byte - b0, 2);
    chk("enable_drop_busy", int'(busy), 0);
    chk("enable_drop_len_out", int'(len_out), 4);
    e0 = n_eof;
    send_hdr();
    exp_q.push_back(8'h01);
    send_byte(8'h01);
    send_byte(8'h10);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    chk_zero("reset_mid_crc_outputs");
    rst_n = 1'b1;
    idle(2);
    chk("reset_mid_crc_eof", n_eof - e0, 0);
    run_vec(vecs[2], "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
